// File: rtl/power_sequencer_if.sv
// power_sequencer_if
//   Bundles the sequencer's handshake and status signals.
//   master : side that supplies ready acknowledges and restart requests
//            and observes resets/status (system controller or bench).
//   slave  : the power_sequencer itself.
// Signals:
//   stage_ready  [NUM_STAGES-1:0]  per-stage ready acknowledge (level)
//   soft_restart                   single-cycle request to re-run the sequence
//   stage_reset  [NUM_STAGES-1:0]  per-stage reset, active high
//   mute                           DAC mute, active high
//   sys_ready                      all stages up and unmuted
//   fault                          latched sequencing/run fault
//   fault_stage  [2:0]             index of the faulting stage
interface power_sequencer_if #(
    parameter int NUM_STAGES = 4
);
    logic [NUM_STAGES-1:0] stage_ready;
    logic                  soft_restart;
    logic [NUM_STAGES-1:0] stage_reset;
    logic                  mute;
    logic                  sys_ready;
    logic                  fault;
    logic [2:0]            fault_stage;

    modport master (
        output stage_ready,
        output soft_restart,
        input  stage_reset,
        input  mute,
        input  sys_ready,
        input  fault,
        input  fault_stage
    );

    modport slave (
        input  stage_ready,
        input  soft_restart,
        output stage_reset,
        output mute,
        output sys_ready,
        output fault,
        output fault_stage
    );
endinterface

// File: rtl/power_sequencer.sv
// power_sequencer
//   Releases subsystem resets one at a time (oscillators, filter, envelopes,
//   DAC), waiting for each stage's ready acknowledge before moving on, then
//   unmutes the audio path. Timeouts and loss of ready in run latch a fault
//   that holds until soft_restart.
// Ports:
//   clk      : system clock
//   reset_n  : asynchronous active-low reset
//   sb       : power_sequencer_if.slave (stage_ready, soft_restart in;
//              stage_reset, mute, sys_ready, fault, fault_stage out)
// Optional feature:
//   SEQ_AUTO_RETRY_EN : when defined, a WAIT timeout re-runs the whole
//   sequence up to three times before the fault is latched.
// All outputs come straight from flops.
module power_sequencer #(
    parameter int NUM_STAGES  = 4,
    parameter int STAGE_DELAY = 16,
    parameter int TIMEOUT     = 1024,
    parameter int CW          = 12
) (
    input  logic             clk,
    input  logic             reset_n,
    power_sequencer_if.slave sb
);

    typedef enum logic [2:0] {
        ST_SETTLE = 3'd0,
        ST_WAIT   = 3'd1,
        ST_UNMUTE = 3'd2,
        ST_RUN    = 3'd3,
        ST_FAULT  = 3'd4
    } state_t;

    localparam logic [CW-1:0]         DLY_LAST = CW'(STAGE_DELAY - 1);
    localparam logic [CW-1:0]         TO_LAST  = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0]         CNT_INC  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [2:0]            LAST_IDX = 3'(NUM_STAGES - 1);
    localparam logic [NUM_STAGES-1:0] ALL_ONES = {NUM_STAGES{1'b1}};
    localparam logic [NUM_STAGES-1:0] ONE_HOT0 = {{(NUM_STAGES-1){1'b0}}, 1'b1};

    // Lowest index whose ready bit is low; 0 when none is low.
    function automatic logic [2:0] lowest_zero(input logic [NUM_STAGES-1:0] v);
        logic [2:0] r;
        r = 3'd0;
        for (int i = NUM_STAGES - 1; i >= 0; i--) begin
            r = v[i] ? r : 3'(i);
        end
        return r;
    endfunction

    state_t                state_r;
    state_t                state_nx_s;
    logic [2:0]            idx_r;
    logic [2:0]            idx_nx_s;
    logic [CW-1:0]         cnt_r;
    logic [CW-1:0]         cnt_nx_s;

    logic [NUM_STAGES-1:0] stage_reset_r;
    logic [NUM_STAGES-1:0] stage_reset_nx_s;
    logic                  mute_r;
    logic                  mute_nx_s;
    logic                  sys_ready_r;
    logic                  sys_ready_nx_s;
    logic                  fault_r;
    logic                  fault_nx_s;
    logic [2:0]            fault_stage_r;
    logic [2:0]            fault_stage_nx_s;

    logic [NUM_STAGES-1:0] sel_mask_s;
    logic                  ready_sel_s;
    logic                  all_up_s;
    logic                  dly_done_s;
    logic                  to_done_s;
    logic                  restart_s;
    logic                  retry_ok_s;

`ifdef SEQ_AUTO_RETRY_EN
    logic [1:0]            retry_r;
    logic [1:0]            retry_nx_s;
    assign retry_ok_s = (retry_r != 2'd3);
`else
    assign retry_ok_s = 1'b0;
`endif

    // Stage selection is done with a one-hot mask so no index can run past
    // NUM_STAGES when it is not a power of two.
    assign sel_mask_s  = ONE_HOT0 << idx_r;
    assign ready_sel_s = |(sb.stage_ready & sel_mask_s);
    assign all_up_s    = &sb.stage_ready;
    assign dly_done_s  = (cnt_r == DLY_LAST);
    assign to_done_s   = (cnt_r == TO_LAST);
    assign restart_s   = sb.soft_restart;

    // State register: FSM state, stage index, cycle counter (and retry count).
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r <= ST_SETTLE;
            idx_r   <= 3'd0;
            cnt_r   <= '0;
`ifdef SEQ_AUTO_RETRY_EN
            retry_r <= 2'd0;
`endif
        end else begin
            state_r <= state_nx_s;
            idx_r   <= idx_nx_s;
            cnt_r   <= cnt_nx_s;
`ifdef SEQ_AUTO_RETRY_EN
            retry_r <= retry_nx_s;
`endif
        end
    end

    // Next-state logic: counter is zeroed on every state change, so it
    // never runs past its terminal compare.
    always_comb begin
        state_nx_s = state_r;
        idx_nx_s   = idx_r;
        cnt_nx_s   = cnt_r;
`ifdef SEQ_AUTO_RETRY_EN
        retry_nx_s = retry_r;
`endif
        case (state_r)
            ST_SETTLE: begin
                if (dly_done_s) begin
                    state_nx_s = ST_WAIT;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_INC;
                end
            end
            ST_WAIT: begin
                // Ready sampled on the timeout edge still counts as ready.
                if (ready_sel_s) begin
                    cnt_nx_s = '0;
                    if (idx_r == LAST_IDX) begin
                        state_nx_s = ST_UNMUTE;
                    end else begin
                        state_nx_s = ST_SETTLE;
                        idx_nx_s   = idx_r + 3'd1;
                    end
                end else if (to_done_s) begin
                    cnt_nx_s = '0;
                    idx_nx_s = 3'd0;
                    if (retry_ok_s) begin
                        state_nx_s = ST_SETTLE;
`ifdef SEQ_AUTO_RETRY_EN
                        retry_nx_s = retry_r + 2'd1;
`endif
                    end else begin
                        state_nx_s = ST_FAULT;
                    end
                end else begin
                    cnt_nx_s = cnt_r + CNT_INC;
                end
            end
            ST_UNMUTE: begin
                if (dly_done_s) begin
                    state_nx_s = ST_RUN;
                    cnt_nx_s   = '0;
                end else begin
                    cnt_nx_s   = cnt_r + CNT_INC;
                end
            end
            ST_RUN: begin
                // Restart wins over a simultaneous ready drop.
                if (restart_s) begin
                    state_nx_s = ST_SETTLE;
                    idx_nx_s   = 3'd0;
                    cnt_nx_s   = '0;
`ifdef SEQ_AUTO_RETRY_EN
                    retry_nx_s = 2'd0;
`endif
                end else if (!all_up_s) begin
                    state_nx_s = ST_FAULT;
                    idx_nx_s   = 3'd0;
                end else begin
                    state_nx_s = ST_RUN;
                end
            end
            ST_FAULT: begin
                if (restart_s) begin
                    state_nx_s = ST_SETTLE;
                    idx_nx_s   = 3'd0;
                    cnt_nx_s   = '0;
`ifdef SEQ_AUTO_RETRY_EN
                    retry_nx_s = 2'd0;
`endif
                end else begin
                    state_nx_s = ST_FAULT;
                end
            end
            default: begin
                state_nx_s = ST_SETTLE;
                idx_nx_s   = 3'd0;
                cnt_nx_s   = '0;
            end
        endcase
    end

    // Output logic: next values of the registered outputs, changing only on
    // the edge that makes the matching state transition.
    always_comb begin
        stage_reset_nx_s = stage_reset_r;
        mute_nx_s        = mute_r;
        sys_ready_nx_s   = sys_ready_r;
        fault_nx_s       = fault_r;
        fault_stage_nx_s = fault_stage_r;
        case (state_r)
            ST_SETTLE: begin
                if (dly_done_s) begin
                    stage_reset_nx_s = stage_reset_r & ~sel_mask_s;
                end else begin
                    stage_reset_nx_s = stage_reset_r;
                end
            end
            ST_WAIT: begin
                if (!ready_sel_s && to_done_s) begin
                    stage_reset_nx_s = ALL_ONES;
                    mute_nx_s        = 1'b1;
                    sys_ready_nx_s   = 1'b0;
                    if (retry_ok_s) begin
                        fault_nx_s = fault_r;
                    end else begin
                        fault_nx_s       = 1'b1;
                        fault_stage_nx_s = idx_r;
                    end
                end else begin
                    stage_reset_nx_s = stage_reset_r;
                end
            end
            ST_UNMUTE: begin
                if (dly_done_s) begin
                    mute_nx_s      = 1'b0;
                    sys_ready_nx_s = 1'b1;
                end else begin
                    mute_nx_s      = mute_r;
                end
            end
            ST_RUN: begin
                if (restart_s) begin
                    stage_reset_nx_s = ALL_ONES;
                    mute_nx_s        = 1'b1;
                    sys_ready_nx_s   = 1'b0;
                    fault_nx_s       = 1'b0;
                    fault_stage_nx_s = 3'd0;
                end else if (!all_up_s) begin
                    stage_reset_nx_s = ALL_ONES;
                    mute_nx_s        = 1'b1;
                    sys_ready_nx_s   = 1'b0;
                    fault_nx_s       = 1'b1;
                    fault_stage_nx_s = lowest_zero(sb.stage_ready);
                end else begin
                    sys_ready_nx_s   = sys_ready_r;
                end
            end
            ST_FAULT: begin
                if (restart_s) begin
                    stage_reset_nx_s = ALL_ONES;
                    mute_nx_s        = 1'b1;
                    sys_ready_nx_s   = 1'b0;
                    fault_nx_s       = 1'b0;
                    fault_stage_nx_s = 3'd0;
                end else begin
                    fault_nx_s       = fault_r;
                end
            end
            default: begin
                stage_reset_nx_s = ALL_ONES;
                mute_nx_s        = 1'b1;
                sys_ready_nx_s   = 1'b0;
                fault_nx_s       = 1'b0;
                fault_stage_nx_s = 3'd0;
            end
        endcase
    end

    // Output register: every output is a flop, forced to its safe value by reset_n.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            stage_reset_r <= ALL_ONES;
            mute_r        <= 1'b1;
            sys_ready_r   <= 1'b0;
            fault_r       <= 1'b0;
            fault_stage_r <= 3'd0;
        end else begin
            stage_reset_r <= stage_reset_nx_s;
            mute_r        <= mute_nx_s;
            sys_ready_r   <= sys_ready_nx_s;
            fault_r       <= fault_nx_s;
            fault_stage_r <= fault_stage_nx_s;
        end
    end

    assign sb.stage_reset = stage_reset_r;
    assign sb.mute        = mute_r;
    assign sb.sys_ready   = sys_ready_r;
    assign sb.fault       = fault_r;
    assign sb.fault_stage = fault_stage_r;

endmodule
